// File: rtl/serial_divider_pkg.sv
// serial_divider_pkg: shared width default and FSM state type for the serial divider
package serial_divider_pkg;
  localparam int DEF_W = 8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/serial_divider_div_step.sv
// div_step: one restoring shift/compare/subtract iteration
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   p,
  input  logic         bit_in,
  input  logic [W-1:0] d,
  output logic [W:0]   p_next,
  output logic         q_bit
);
  logic [W+1:0] s;
  always_comb begin
    s      = {p, bit_in};
    q_bit  = s >= {2'b00, d};
    p_next = (W+1)'(q_bit ? s - {2'b00, d} : s);
  end
endmodule

// File: rtl/serial_divider.sv
// serial_divider: restoring divider, one quotient bit per clock, MSB first
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] Dividend,
  input  logic [W-1:0]   Divisor,
  output logic [2*W-1:0] Quotient,
  output logic [W-1:0]   Remainder,
  output logic           ready,
  output logic           div_by_zero
);
  localparam int CW = $clog2(2*W) + 1;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     p_q, p_d, p_n;
  logic [2*W-1:0] dvd_q, dvd_d, quot_q, quot_d;
  logic [W-1:0]   dvs_q, dvs_d, rem_q, rem_d;
  logic           dbz_q, dbz_d, q_bit;
  div_step #(.W(W)) u_step (
    .p      (p_q),
    .bit_in (dvd_q[2*W-1]),
    .d      (dvs_q),
    .p_next (p_n),
    .q_bit  (q_bit)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    if (start) begin
      state_d = BUSY;
      cnt_d   = '0;
      p_d     = '0;
      dvd_d   = Dividend;
      dvs_d   = Divisor;
      quot_d  = '0;
      rem_d   = '0;
      dbz_d   = Divisor == '0;
    end else if (state_q == BUSY) begin
      if (dbz_q) begin
        state_d = DONE;
        quot_d  = '1;
        rem_d   = dvd_q[W-1:0];
      end else begin
        p_d    = p_n;
        dvd_d  = dvd_q << 1;
        quot_d = {quot_q[2*W-2:0], q_bit};
        cnt_d  = cnt_q + 1'b1;
        // last iteration: the final partial remainder is the result
        if (cnt_q == CW'(2*W-1)) begin
          state_d = DONE;
          rem_d   = p_n[W-1:0];
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end
  assign Quotient    = quot_q;
  assign Remainder   = rem_q;
  assign ready       = state_q == DONE;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_serial_divider.sv
// tb_serial_divider: randomized and directed checks against an arithmetic model
module tb_serial_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] Dividend = '0;
  logic [7:0]  Divisor = '0;
  logic [15:0] Quotient;
  logic [7:0]  Remainder;
  logic        ready, div_by_zero;
  int n_chk = 0;
  int n_pass = 0;

  serial_divider #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .ready(ready), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic kick(input logic [15:0] a, input logic [7:0] b, input int hold);
    @(negedge clk);
    Dividend = a;
    Divisor  = b;
    start    = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  // one full operation; scramble perturbs the operand inputs while busy
  task automatic run(input string tag, input logic [15:0] a, input logic [7:0] b,
                     input int hold, input bit scramble);
    int n;
    int lat;
    logic [15:0] eq;
    logic [7:0]  er;
    lat = (b == 0) ? 1 : 16;
    eq  = (b == 0) ? 16'hFFFF : a / b;
    er  = (b == 0) ? a[7:0] : 8'(a % b);
    kick(a, b, hold);
    if (tag != "rnd") begin
      chk({tag, "_clr_q"}, Quotient, 0);
      chk({tag, "_clr_r"}, Remainder, 0);
    end
    n = 0;
    while (!ready && n < 40) begin
      if (scramble) begin
        Dividend = 16'($urandom);
        Divisor  = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_dbz"}, div_by_zero, b == 0);
    if (b != 0) begin
      chk({tag, "_id"}, Quotient * b + Remainder, a);
      chk({tag, "_rlt"}, Remainder < b, 1);
    end
  endtask

  initial begin
    #1;
    chk("rst_rdy", ready, 0);
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    start = 1'b1;
    Divisor = 8'd5;
    @(negedge clk);
    chk("rst_win", ready, 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_hold", ready, 0);

    run("d1000_7", 16'd1000, 8'd7, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("stable_rdy", ready, 1);
    chk("stable_q", Quotient, 142);
    chk("stable_r", Remainder, 6);
    run("dmax_1", 16'd65535, 8'd1, 1, 1'b1);
    run("dmax_255", 16'd65535, 8'd255, 1, 1'b0);
    run("dz", 16'h1234, 8'd0, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("dz_hold", ready, 1);
    run("dbz_clr", 16'd77, 8'd10, 1, 1'b0);
    run("hold3", 16'd4321, 8'd13, 3, 1'b0);

    kick(16'd100, 8'd3, 1);
    repeat (4) @(negedge clk);
    chk("abort_busy", ready, 0);
    run("abort", 16'd200, 8'd9, 1, 1'b0);

    kick(16'd500, 8'd6, 1);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdy", ready, 0);
    chk("mid_rst_q", Quotient, 0);
    chk("mid_rst_r", Remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", ready, 0);
    run("after_rst", 16'd500, 8'd6, 1, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(1, 255));
      if (i % 4 == 0) b = 8'($urandom_range(1, 3));
      run("rnd", 16'($urandom), b, 1, i[0]);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_divider.md
SERIAL_DIVIDER -- requirements
Module: serial_divider

Interface
REQ-001 Parameter: W, 8, divisor/remainder width; the dividend and quotient are 2*W bits wide.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  load operands and begin a division; sampled on the rising edge of clk.
REQ-005 Port: Dividend  input  2*W  unsigned dividend; sampled only on the start edge.
REQ-006 Port: Divisor  input  W  unsigned divisor; sampled only on the start edge.
REQ-007 Port: Quotient  output  2*W  registered unsigned quotient; valid while ready=1.
REQ-008 Port: Remainder  output  W  registered unsigned remainder; valid while ready=1.
REQ-009 Port: ready  output  1  result valid, block idle.
REQ-010 Port: div_by_zero  output  1  the last accepted operation had Divisor=0; valid while ready=1.

Function
REQ-011 The block SHALL implement a restoring shift-subtract divider that resolves one quotient bit per clock, MSB first.
REQ-012 State machine: IDLE -> BUSY on start; BUSY -> DONE after 2*W iterations; DONE -> BUSY on start; DONE holds otherwise.
REQ-013 A start=1 edge in any state SHALL load the operands, clear the iteration counter, clear Quotient and Remainder, and drop ready on that edge.
REQ-014 A start during BUSY SHALL abort the current operation without producing a result and restart with the new operands.
REQ-015 Each BUSY edge: partial remainder P (W+1 bits) := {P[W-1:0], next dividend bit}; if P >= Divisor then P := P - Divisor and quotient bit := 1, else quotient bit := 0.
REQ-016 The compare/subtract SHALL use W+1 bits so that no carry is lost when P >= 2^W.
REQ-017 ready SHALL assert exactly 2*W rising edges after the start edge (16 for W=8) and SHALL stay high until the next start or rst.
REQ-018 While ready=1: Quotient = floor(Dividend/Divisor), Remainder = Dividend mod Divisor, and both SHALL be stable.
REQ-019 Divisor=0: the block SHALL go from the start edge to DONE on the next edge (1-cycle latency), with div_by_zero=1, Quotient = all ones, and Remainder = Dividend[W-1:0].
REQ-020 div_by_zero SHALL be cleared on every start with Divisor != 0.
REQ-021 While BUSY, changes on Dividend/Divisor SHALL have no effect.
REQ-022 start held high for several cycles SHALL restart the operation on every edge; the result appears 2*W edges after the last start edge.
REQ-023 Quotient overflow is impossible by width; no saturation logic is required.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, counter 0, Quotient 0, Remainder 0, div_by_zero 0, and ready 0, independent of clk.
REQ-025 rst asserted mid-operation SHALL discard the operation; after release, the block SHALL wait in IDLE for start.
REQ-026 If rst and start are both high, rst SHALL win.

Structure
REQ-027 The shared package SHALL hold the default W and the state typedef (IDLE, BUSY, DONE).
REQ-028 The per-iteration shift/compare/subtract SHALL be one combinational sub-module, div_step (inputs: P, dividend bit, Divisor; outputs: next P, quotient bit).
REQ-029 The counter width SHALL be clog2(2*W)+1 bits.

Verification
REQ-030 Dividend=1000, Divisor=7, start 1 cycle -> ready after 16 edges; Quotient=142, Remainder=6, div_by_zero=0.
REQ-031 Dividend=65535, Divisor=1 -> Quotient=65535, Remainder=0; Dividend=65535, Divisor=255 -> Quotient=257, Remainder=0.
REQ-032 Dividend=0x1234, Divisor=0 -> ready 1 edge after start, div_by_zero=1, Quotient=0xFFFF, Remainder=0x34.
REQ-033 Start 100/3; at iteration 5, start 200/9 -> single result after 16 edges from the second start: Quotient=22, Remainder=2.
REQ-034 Assert rst at iteration 8 of 500/6 -> all outputs 0 immediately; ready stays 0 until a new start; the next operation 500/6 -> Quotient=83, Remainder=2.
REQ-035 Random regression: 10k random operand pairs (Divisor != 0) checked against Quotient*Divisor + Remainder = Dividend and Remainder < Divisor.
